// File: rtl/ro_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// ro_test_pattern_gen
//
// Readout test-pattern generator that sits between the pixel TDC output and
// the readout serializer/FIFO.
//
//   TestRO = 0 : registered pass-through of TDC words (1-cycle latency,
//                DataOutReady ignored).
//   TestRO = 1 : emits one of four test patterns with valid/ready
//                backpressure, either continuously or as a finite burst.
//
// Patterns (n = number of words accepted so far in this run, from 0):
//   mode 0 : {HEADER, CFGROTest, n[CW-1:0]}          (wraps without stopping)
//   mode 1 : {HEADER, CFGROTest, 0..0, prbs7}        (x^7+x^6+1, seed 7'h7F)
//   mode 2 : FixedPattern on even n, ~FixedPattern on odd n
//   mode 3 : one-hot DW-bit word with bit (n mod DW) set
//
// Optional feature macro: ROTEST_PRBS_EN
//   defined   : mode 1 produces the PRBS7 payload.
//   undefined : PRBS logic is not built and mode 1 behaves exactly as mode 0.
//
// Parameters
//   DW      data word width
//   IDW     pixel-ID width
//   CW      counter / payload field width (>= 7, and DW-IDW-CW >= 1)
//   HEADER  header constant, DW-IDW-CW bits
//
// Ports
//   CLK           clock
//   RSTn          asynchronous active-low reset
//   TestRO        1 = test mode, 0 = pass-through
//   TestMode      pattern select (latched on entry into RUN)
//   CFGROTest     pixel ID inserted into modes 0/1
//   FixedPattern  word for mode 2 (latched on entry into RUN)
//   BurstLen      words per burst, 0 = continuous (latched on entry into RUN)
//   DataIn        TDC data word
//   DataInValid   TDC data valid
//   DataOut       registered output word
//   DataOutValid  DataOut valid
//   DataOutReady  downstream accept (only honoured in test mode)
//   Busy          FSM in RUN
//   Done          FSM in DONE (burst complete)
// ---------------------------------------------------------------------------
module ro_test_pattern_gen #(
  parameter int                     DW     = 30,
  parameter int                     IDW    = 4,
  parameter int                     CW     = 16,
  parameter logic [DW-IDW-CW-1:0]   HEADER = 10'b1010101010
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            TestRO,
  input  logic [1:0]      TestMode,
  input  logic [IDW-1:0]  CFGROTest,
  input  logic [DW-1:0]   FixedPattern,
  input  logic [CW-1:0]   BurstLen,
  input  logic [DW-1:0]   DataIn,
  input  logic            DataInValid,
  output logic [DW-1:0]   DataOut,
  output logic            DataOutValid,
  input  logic            DataOutReady,
  output logic            Busy,
  output logic            Done
);

  localparam int HDRW = DW - IDW - CW;

  localparam logic [DW-1:0] ONEHOT_INIT = DW'(1);
`ifdef ROTEST_PRBS_EN
  localparam logic [6:0]    PRBS_INIT   = 7'h7F;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  // Run configuration captured on the IDLE->RUN cycle.
  logic [1:0]      mode_reg;
  logic [CW-1:0]   burst_reg;
  logic [DW-1:0]   fixed_reg;

  // Generator state for the word currently due (index n).
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   onehot_reg;
`ifdef ROTEST_PRBS_EN
  logic [6:0]      prbs_reg;
`endif

  logic [DW-1:0]   dout_reg;
  logic            dvalid_reg;

  // Handshake / control
  logic            accept;
  logic            load;
  logic            burst_hit;

  // Generator state for the word to present next: stepped if the current
  // word is being accepted on this edge, otherwise unchanged.
  logic [CW-1:0]   cnt_gen;
  logic [DW-1:0]   onehot_rot;
  logic [DW-1:0]   onehot_gen;
`ifdef ROTEST_PRBS_EN
  logic [6:0]      prbs_step;
  logic [6:0]      prbs_gen;
  logic [CW-1:0]   prbs_payload;
  logic [DW-1:0]   prbs_word;
`endif

  logic [DW-1:0]   cnt_word;
  logic [DW-1:0]   fixed_word;
  logic [DW-1:0]   pattern_word;

  assign DataOut      = dout_reg;
  assign DataOutValid = dvalid_reg;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // A new word may be loaded whenever the output slot is empty or its
  // current word is leaving; this gives back-to-back words under
  // continuous ready.
  assign accept = (state_reg == S_RUN) && dvalid_reg && DataOutReady;
  assign load   = (state_reg == S_RUN) && (!dvalid_reg || DataOutReady);

  assign cnt_gen = accept ? (cnt_reg + CW'(1)) : cnt_reg;

  // The accepted count after this edge equals BurstLen: this accept is the
  // last word of the burst.
  assign burst_hit = accept && (burst_reg != '0) && (cnt_gen == burst_reg);

  // -------------------------------------------------------------------------
  // Pattern generators
  // -------------------------------------------------------------------------
  genvar gi;

  // Rotate left by one, bit DW-1 wraps into bit 0.
  generate
    for (gi = 0; gi < DW; gi++) begin : g_onehot_rot
      assign onehot_rot[gi] = onehot_reg[(gi + DW - 1) % DW];
    end
  endgenerate

  assign onehot_gen = accept ? onehot_rot : onehot_reg;

  // Odd words carry the complement; the index parity is the LSB of cnt.
  generate
    for (gi = 0; gi < DW; gi++) begin : g_fixed_word
      assign fixed_word[gi] = fixed_reg[gi] ^ cnt_gen[0];
    end
  endgenerate

  assign cnt_word = {HEADER[HDRW-1:0], CFGROTest, cnt_gen};

`ifdef ROTEST_PRBS_EN
  // PRBS7, x^7 + x^6 + 1, shifting left with the feedback into bit 0.
  assign prbs_step = {prbs_reg[5:0], prbs_reg[6] ^ prbs_reg[5]};
  assign prbs_gen  = accept ? prbs_step : prbs_reg;

  // Zero-extend the 7-bit sequence into the CW-bit payload field.
  generate
    for (gi = 0; gi < CW; gi++) begin : g_prbs_payload
      if (gi < 7) begin : g_lfsr_bit
        assign prbs_payload[gi] = prbs_gen[gi];
      end else begin : g_zero_bit
        assign prbs_payload[gi] = 1'b0;
      end
    end
  endgenerate

  assign prbs_word = {HEADER[HDRW-1:0], CFGROTest, prbs_payload};
`endif

  // Without the PRBS build, mode 1 falls into the default (counter) arm.
  always_comb begin
    pattern_word = cnt_word;
    case (mode_reg)
`ifdef ROTEST_PRBS_EN
      2'd1:    pattern_word = prbs_word;
`endif
      2'd2:    pattern_word = fixed_word;
      2'd3:    pattern_word = onehot_gen;
      default: pattern_word = cnt_word;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic. TestRO low returns to IDLE from any state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!TestRO) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  state_next = S_RUN;
        S_RUN:   state_next = burst_hit ? S_DONE : S_RUN;
        S_DONE:  state_next = S_DONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_reg)
      S_RUN:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: begin
        Busy = 1'b0;
        Done = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_reg   <= 2'd0;
      burst_reg  <= '0;
      fixed_reg  <= '0;
      cnt_reg    <= '0;
      onehot_reg <= ONEHOT_INIT;
`ifdef ROTEST_PRBS_EN
      prbs_reg   <= PRBS_INIT;
`endif
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
    end else if (!TestRO) begin
      // Pass-through; any pending test word is simply overwritten. A word
      // accepted on this same edge has already left downstream.
      dout_reg   <= DataIn;
      dvalid_reg <= DataInValid;
      cnt_reg    <= '0;
      onehot_reg <= ONEHOT_INIT;
`ifdef ROTEST_PRBS_EN
      prbs_reg   <= PRBS_INIT;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Entry into RUN: capture the run configuration. The first word
          // is loaded on the following edge from these captured values.
          mode_reg   <= TestMode;
          burst_reg  <= BurstLen;
          fixed_reg  <= FixedPattern;
          cnt_reg    <= '0;
          onehot_reg <= ONEHOT_INIT;
`ifdef ROTEST_PRBS_EN
          prbs_reg   <= PRBS_INIT;
`endif
          dvalid_reg <= 1'b0;
        end
        S_RUN: begin
          if (accept) begin
            cnt_reg    <= cnt_gen;
            onehot_reg <= onehot_gen;
`ifdef ROTEST_PRBS_EN
            prbs_reg   <= prbs_gen;
`endif
          end
          if (burst_hit) begin
            dvalid_reg <= 1'b0;
          end else if (load) begin
            dout_reg   <= pattern_word;
            dvalid_reg <= 1'b1;
          end
        end
        default: begin
          dvalid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_test_pattern_gen.sv
module tb_ro_test_pattern_gen;

  localparam int DW  = 30;
  localparam int IDW = 4;
  localparam int CW  = 16;
  localparam logic [9:0] HDR = 10'b1010101010;

  logic            CLK = 1'b0;
  logic            RSTn;
  logic            TestRO;
  logic [1:0]      TestMode;
  logic [IDW-1:0]  CFGROTest;
  logic [DW-1:0]   FixedPattern;
  logic [CW-1:0]   BurstLen;
  logic [DW-1:0]   DataIn;
  logic            DataInValid;
  logic [DW-1:0]   DataOut;
  logic            DataOutValid;
  logic            DataOutReady;
  logic            Busy;
  logic            Done;

  ro_test_pattern_gen #(
    .DW  (DW),
    .IDW (IDW),
    .CW  (CW)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .TestRO       (TestRO),
    .TestMode     (TestMode),
    .CFGROTest    (CFGROTest),
    .FixedPattern (FixedPattern),
    .BurstLen     (BurstLen),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 CLK = ~CLK;

  int              checks = 0;
  int              errors = 0;
  int              acc_cnt;
  int              acc_limit;
  bit              mon_en;
  bit              hold_pending;
  logic [DW-1:0]   hold_word;
  logic [DW-1:0]   exp_q[$];

  function automatic logic [DW-1:0] cnt_word(input logic [IDW-1:0] id, input logic [CW-1:0] c);
    return {HDR, id, c};
  endfunction

  function automatic logic [DW-1:0] prbs_word(input logic [IDW-1:0] id, input logic [6:0] p);
    return {HDR, id, 9'd0, p};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: called at the falling edge, away from the active edge.
  task automatic observe();
    logic [DW-1:0] exp_w;
    if (mon_en) begin
      if (hold_pending) begin
        check("hold_data", 64'(DataOut), 64'(hold_word));
        check("hold_valid", 64'(DataOutValid), 64'(1'b1));
      end
      if (DataOutValid && DataOutReady) begin
        if (acc_cnt < acc_limit) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(DataOutValid), 64'(1'b0));
          end else begin
            exp_w = exp_q.pop_front();
            check("word", 64'(DataOut), 64'(exp_w));
          end
        end
        acc_cnt++;
      end
      hold_pending = DataOutValid && !DataOutReady;
      hold_word    = DataOut;
    end else begin
      hold_pending = 1'b0;
    end
  endtask

  // One clock: observe at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_test(input logic [1:0] m, input logic [IDW-1:0] id,
                            input logic [DW-1:0] fp, input logic [CW-1:0] bl);
    TestMode     = m;
    CFGROTest    = id;
    FixedPattern = fp;
    BurstLen     = bl;
    DataInValid  = 1'b0;
    TestRO       = 1'b1;
    acc_cnt      = 0;
    acc_limit    = 0;
    hold_pending = 1'b0;
    mon_en       = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget, input bit rnd);
    int i;
    i = 0;
    acc_limit = target;
    while (acc_cnt < target && i < budget) begin
      DataOutReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      i++;
    end
    check("accept_count", 64'(acc_cnt), 64'(target));
  endtask

  // After the last accept of a burst: DONE now and stays there, no extras.
  task automatic finish_burst(input int n);
    acc_limit = 32'h4000_0000;
    check("done_set", 64'(Done), 64'(1'b1));
    check("done_valid_low", 64'(DataOutValid), 64'(1'b0));
    check("done_busy_low", 64'(Busy), 64'(1'b0));
    DataOutReady = 1'b1;
    repeat (4) tick();
    check("done_hold", 64'(Done), 64'(1'b1));
    check("done_hold_valid", 64'(DataOutValid), 64'(1'b0));
    check("burst_total", 64'(acc_cnt), 64'(n));
  endtask

  task automatic stop_test();
    DataOutReady = 1'b0;
    DataInValid  = 1'b0;
    TestRO       = 1'b0;
    mon_en       = 1'b0;
    tick();
    check("stop_busy", 64'(Busy), 64'(1'b0));
    check("stop_done", 64'(Done), 64'(1'b0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    tick();
  endtask

  initial begin
    logic [6:0]    p;
    logic [3:0]    pat_vec;
    int            i;

    RSTn = 1'b1; TestRO = 1'b0; TestMode = 2'd0; CFGROTest = '0;
    FixedPattern = '0; BurstLen = '0; DataIn = '0; DataInValid = 1'b0;
    DataOutReady = 1'b0; mon_en = 1'b0; hold_pending = 1'b0;
    acc_cnt = 0; acc_limit = 0; hold_word = '0;

    // Reset
    #2 RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_dataout", 64'(DataOut), 64'(0));
    check("reset_valid", 64'(DataOutValid), 64'(1'b0));
    check("reset_busy", 64'(Busy), 64'(1'b0));
    check("reset_done", 64'(Done), 64'(1'b0));

    // Pass-through
    RSTn = 1'b1;
    DataIn = 30'h1234567; DataInValid = 1'b1;
    @(posedge CLK); #1;
    check("pt_data", 64'(DataOut), 64'(30'h1234567));
    check("pt_valid", 64'(DataOutValid), 64'(1'b1));
    check("pt_busy", 64'(Busy), 64'(1'b0));
    DataIn = 30'h3FFFFFFF; DataInValid = 1'b0; DataOutReady = 1'b0;
    tick();
    check("pt_data2", 64'(DataOut), 64'(30'h3FFFFFFF));
    check("pt_valid_low", 64'(DataOutValid), 64'(1'b0));

    // Mode 0 continuous, 65537 words across the counter wrap
    for (int n = 0; n <= 65536; n++) exp_q.push_back(cnt_word(4'h5, CW'(n)));
    start_test(2'd0, 4'h5, '0, '0);
    run_until(65537, 70000, 1'b0);
    check("cont_busy", 64'(Busy), 64'(1'b1));
    stop_test();

    // Mode 0 burst of 3 with ready pattern 1,0,1,1
    for (int n = 0; n < 3; n++) exp_q.push_back(cnt_word(4'h5, CW'(n)));
    start_test(2'd0, 4'h5, '0, 16'd3);
    DataOutReady = 1'b0;
    i = 0;
    while (!DataOutValid && i < 10) begin
      tick();
      i++;
    end
    check("first_word_seen", 64'(DataOutValid), 64'(1'b1));
    check("first_word_busy", 64'(Busy), 64'(1'b1));
    acc_limit = 3;
    pat_vec = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      DataOutReady = pat_vec[k];
      tick();
    end
    check("burst3_count", 64'(acc_cnt), 64'(3));
    finish_burst(3);
    stop_test();

    // Mode 1 with ID 0 over 128 words (one full PRBS period plus one)
    p = 7'h7F;
    for (int n = 0; n < 128; n++) begin
`ifdef ROTEST_PRBS_EN
      exp_q.push_back(prbs_word(4'h0, p));
      p = {p[5:0], p[6] ^ p[5]};
`else
      exp_q.push_back(cnt_word(4'h0, CW'(n)));
`endif
    end
    start_test(2'd1, 4'h0, '0, 16'd128);
    run_until(128, 400, 1'b0);
    finish_burst(128);
    stop_test();

    // Mode 2 fixed/complement; config changes after entry must be ignored
    exp_q.push_back(30'h15555555);
    exp_q.push_back(30'h2AAAAAAA);
    exp_q.push_back(30'h15555555);
    start_test(2'd2, 4'h3, 30'h15555555, 16'd3);
    tick();
    FixedPattern = '0; TestMode = 2'd3; BurstLen = 16'd1;
    run_until(3, 50, 1'b0);
    finish_burst(3);
    stop_test();

    // Mode 3 walking one over 31 words with random backpressure
    for (int n = 0; n < 31; n++) exp_q.push_back(DW'(1) << (n % DW));
    start_test(2'd3, 4'h0, '0, 16'd31);
    run_until(31, 400, 1'b1);
    finish_burst(31);
    stop_test();

    // TestRO dropped after 4 words of a 10-word burst
    for (int n = 0; n < 4; n++) exp_q.push_back(cnt_word(4'h5, CW'(n)));
    start_test(2'd0, 4'h5, '0, 16'd10);
    run_until(4, 50, 1'b0);
    TestRO = 1'b0; mon_en = 1'b0; DataOutReady = 1'b0;
    DataIn = 30'h0ABCDEF; DataInValid = 1'b1;
    tick();
    check("drop_busy", 64'(Busy), 64'(1'b0));
    check("drop_done", 64'(Done), 64'(1'b0));
    check("drop_pt_data", 64'(DataOut), 64'(30'h0ABCDEF));
    check("drop_pt_valid", 64'(DataOutValid), 64'(1'b1));
    DataInValid = 1'b0;
    tick();
    tick();

    // Restart with BurstLen=1: counter restarts at 0, one word then DONE
    exp_q.push_back(cnt_word(4'hA, 16'd0));
    start_test(2'd0, 4'hA, '0, 16'd1);
    run_until(1, 20, 1'b0);
    finish_burst(1);
    stop_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
